// File: rtl/program_counter_stack_pkg.sv
// Shared definitions for the program counter / return stack slice.
// Holds the operation encoding and the priority decode used by the
// top-level controller.
package program_counter_stack_pkg;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_INC  = 3'd1,
    OP_LOAD = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4
  } pc_op_e;

  // A return outranks a call, a call outranks a load, and a load outranks
  // an increment. Only one operation is carried out per active cycle.
  function automatic pc_op_e decode_op(input logic ret, input logic call,
                                       input logic load, input logic inc);
    if (ret)       return OP_RET;
    else if (call) return OP_CALL;
    else if (load) return OP_LOAD;
    else if (inc)  return OP_INC;
    else           return OP_NONE;
  endfunction

endpackage

// File: rtl/program_counter_stack_return_stack.sv
// return_stack: LIFO storage for return addresses.
// Ports:
//   mclk, i_reset      clock and synchronous active-high reset
//   push, pop          one-cycle requests, qualified internally by full/empty
//   push_data          value written on push
//   top                current top entry, 0 when empty
//   depth              number of occupied entries
//   full, empty        occupancy status
// Reset clears only the occupancy count; the storage itself keeps stale data,
// which is never visible because top is forced to 0 when empty.
module return_stack #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                       mclk,
  input  logic                       i_reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       full,
  output logic                       empty
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DW-1:0]    count;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;

  assign full   = (count == DW'(DEPTH));
  assign empty  = (count == '0);
  assign wr_idx = AW'(count);
  assign rd_idx = AW'(count - DW'(1));
  assign top    = empty ? '0 : mem[rd_idx];
  assign depth  = count;

  always_ff @(posedge mclk) begin
    if (i_reset) begin
      count <= '0;
    end else if (push && !full) begin
      mem[wr_idx] <= push_data;
      count       <= count + DW'(1);
    end else if (pop && !empty) begin
      count <= count - DW'(1);
    end
  end

endmodule

// File: rtl/program_counter_stack.sv
// program_counter_stack: program counter with call/return support.
// Ports:
//   mclk, i_reset      clock and synchronous active-high reset (reset wins
//                      over mclk_en, i_halt and all requests)
//   mclk_en, i_halt    an operation happens only when mclk_en=1 and i_halt=0
//   i_counter_enable   increment request
//   i_load_enable      jump to i_load_data
//   i_call             push counter+1, jump to i_load_data
//   i_return           pop top of stack into the counter
//   i_load_data        jump/call target
//   o_data             counter value
//   o_stack_top        top return address (0 when empty)
//   o_stack_depth      occupied stack entries
//   o_overflow         sticky: call issued while the stack was full
//   o_underflow        sticky: return issued while the stack was empty
module program_counter_stack
  import program_counter_stack_pkg::*;
#(
  parameter int               WIDTH        = 4,
  parameter int               DEPTH        = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                       mclk,
  input  logic                       i_reset,
  input  logic                       mclk_en,
  input  logic                       i_counter_enable,
  input  logic                       i_halt,
  input  logic                       i_load_enable,
  input  logic                       i_call,
  input  logic                       i_return,
  input  logic [WIDTH-1:0]           i_load_data,
  output logic [WIDTH-1:0]           o_data,
  output logic [WIDTH-1:0]           o_stack_top,
  output logic [$clog2(DEPTH+1)-1:0] o_stack_depth,
  output logic                       o_overflow,
  output logic                       o_underflow
);

  logic [WIDTH-1:0] counter;
  logic [WIDTH-1:0] counter_inc;
  logic [WIDTH-1:0] stack_top;
  logic             stack_full;
  logic             stack_empty;
  logic             active;
  pc_op_e           op;
  logic             do_push;
  logic             do_pop;

  assign active      = mclk_en && !i_halt;
  assign op          = decode_op(i_return, i_call, i_load_enable, i_counter_enable);
  assign counter_inc = counter + WIDTH'(1);
  assign do_push     = active && (op == OP_CALL) && !stack_full;
  assign do_pop      = active && (op == OP_RET) && !stack_empty;

  return_stack #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_return_stack (
    .mclk      (mclk),
    .i_reset   (i_reset),
    .push      (do_push),
    .pop       (do_pop),
    .push_data (counter_inc),
    .top       (stack_top),
    .depth     (o_stack_depth),
    .full      (stack_full),
    .empty     (stack_empty)
  );

  always_ff @(posedge mclk) begin
    if (i_reset) begin
      counter     <= RESET_VECTOR;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else if (active) begin
      unique case (op)
        OP_RET: begin
          if (stack_empty) o_underflow <= 1'b1;
          else             counter     <= stack_top;
        end
        OP_CALL: begin
          // The jump happens even when the push is refused on a full stack.
          if (stack_full) o_overflow <= 1'b1;
          counter <= i_load_data;
        end
        OP_LOAD: counter <= i_load_data;
        OP_INC:  counter <= counter_inc;
        default: ;
      endcase
    end
  end

  assign o_data      = counter;
  assign o_stack_top = stack_top;

endmodule

// File: tb/tb_program_counter_stack.sv
module tb_program_counter_stack;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int DW    = $clog2(DEPTH + 1);
  localparam logic [WIDTH-1:0] RV = '0;

  logic             mclk = 1'b0;
  logic             i_reset = 1'b0;
  logic             mclk_en = 1'b0;
  logic             i_counter_enable = 1'b0;
  logic             i_halt = 1'b0;
  logic             i_load_enable = 1'b0;
  logic             i_call = 1'b0;
  logic             i_return = 1'b0;
  logic [WIDTH-1:0] i_load_data = '0;
  logic [WIDTH-1:0] o_data;
  logic [WIDTH-1:0] o_stack_top;
  logic [DW-1:0]    o_stack_depth;
  logic             o_overflow;
  logic             o_underflow;

  int n_checks = 0;
  int n_fails  = 0;

  // reference model state
  int m_pc;
  int m_stack[$];
  bit m_ov;
  bit m_un;

  program_counter_stack #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VECTOR(RV)
  ) dut (
    .mclk(mclk), .i_reset(i_reset), .mclk_en(mclk_en),
    .i_counter_enable(i_counter_enable), .i_halt(i_halt),
    .i_load_enable(i_load_enable), .i_call(i_call), .i_return(i_return),
    .i_load_data(i_load_data), .o_data(o_data), .o_stack_top(o_stack_top),
    .o_stack_depth(o_stack_depth), .o_overflow(o_overflow),
    .o_underflow(o_underflow)
  );

  always #5 mclk = ~mclk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit en, input bit halt,
                            input bit ce, input bit ld, input bit call,
                            input bit ret, input int data);
    if (rst) begin
      m_pc = RV;
      m_stack.delete();
      m_ov = 0;
      m_un = 0;
    end else if (en && !halt) begin
      if (ret) begin
        if (m_stack.size() == 0) m_un = 1;
        else m_pc = m_stack.pop_back();
      end else if (call) begin
        if (m_stack.size() < DEPTH) m_stack.push_back((m_pc + 1) % (1 << WIDTH));
        else m_ov = 1;
        m_pc = data;
      end else if (ld) begin
        m_pc = data;
      end else if (ce) begin
        m_pc = (m_pc + 1) % (1 << WIDTH);
      end
    end
  endtask

  task automatic check_all();
    chk("o_data", int'(o_data), m_pc);
    chk("o_stack_top", int'(o_stack_top), (m_stack.size() == 0) ? 0 : m_stack[$]);
    chk("o_stack_depth", int'(o_stack_depth), m_stack.size());
    chk("o_overflow", int'(o_overflow), int'(m_ov));
    chk("o_underflow", int'(o_underflow), int'(m_un));
  endtask

  // drive one cycle, update the model at the edge, check 1 time unit later
  task automatic cyc(input bit rst, input bit en, input bit halt, input bit ce,
                     input bit ld, input bit call, input bit ret, input int data);
    i_reset = rst; mclk_en = en; i_halt = halt; i_counter_enable = ce;
    i_load_enable = ld; i_call = call; i_return = ret;
    i_load_data = WIDTH'(data);
    @(posedge mclk);
    model_step(rst, en, halt, ce, ld, call, ret, data);
    #1;
    check_all();
  endtask

  task automatic do_reset();     cyc(1, 1, 0, 0, 0, 0, 0, 0); endtask
  task automatic do_inc();       cyc(0, 1, 0, 1, 0, 0, 0, 0); endtask
  task automatic do_load(int d); cyc(0, 1, 0, 0, 1, 0, 0, d); endtask
  task automatic do_call(int d); cyc(0, 1, 0, 0, 0, 1, 0, d); endtask
  task automatic do_ret();       cyc(0, 1, 0, 0, 0, 0, 1, 0); endtask

  initial begin
    m_pc = 0; m_ov = 0; m_un = 0;

    // increment sweep with wrap
    do_reset();
    chk("reset_data", int'(o_data), 0);
    chk("reset_depth", int'(o_stack_depth), 0);
    for (int i = 0; i < 17; i++) begin
      chk("inc_seq", int'(o_data), i % 16);
      do_inc();
    end
    chk("inc_wrap_end", int'(o_data), 1);

    // single call / return
    do_reset();
    do_load(5);
    do_call(12);
    chk("call_data", int'(o_data), 12);
    chk("call_top", int'(o_stack_top), 6);
    chk("call_depth", int'(o_stack_depth), 1);
    do_ret();
    chk("ret_data", int'(o_data), 6);
    chk("ret_depth", int'(o_stack_depth), 0);

    // nested calls to overflow, then unwind
    do_reset();
    do_call(1); do_call(2); do_call(3); do_call(4); do_call(8);
    chk("ovf_depth", int'(o_stack_depth), 4);
    chk("ovf_flag", int'(o_overflow), 1);
    chk("ovf_data", int'(o_data), 8);
    chk("ovf_top", int'(o_stack_top), 4);
    for (int i = 4; i >= 1; i--) begin
      do_ret();
      chk("unwind_data", int'(o_data), i);
    end
    chk("ovf_sticky", int'(o_overflow), 1);

    // underflow is sticky until reset
    do_reset();
    do_load(3);
    do_ret();
    chk("unf_data", int'(o_data), 3);
    chk("unf_flag", int'(o_underflow), 1);
    do_inc(); do_call(7); do_ret();
    chk("unf_sticky", int'(o_underflow), 1);
    do_reset();
    chk("unf_cleared", int'(o_underflow), 0);

    // simultaneous requests: return wins
    do_load(8);
    do_call(0);
    chk("prio_setup_top", int'(o_stack_top), 9);
    cyc(0, 1, 0, 1, 1, 1, 1, 5);
    chk("prio_data", int'(o_data), 9);
    chk("prio_depth", int'(o_stack_depth), 0);
    do_load(8);
    do_call(0);
    cyc(0, 1, 1, 1, 1, 1, 1, 5);
    chk("halt_data", int'(o_data), 0);
    chk("halt_depth", int'(o_stack_depth), 1);
    cyc(0, 0, 0, 1, 1, 1, 1, 5);
    chk("noen_data", int'(o_data), 0);
    chk("noen_top", int'(o_stack_top), 9);

    // call wrap, then reset under halt
    do_reset();
    do_load(15);
    do_call(15);
    chk("wrap_push", int'(o_stack_top), 0);
    chk("wrap_data", int'(o_data), 15);
    cyc(1, 0, 1, 1, 0, 1, 0, 3);
    chk("rst_halt_data", int'(o_data), int'(RV));
    chk("rst_halt_depth", int'(o_stack_depth), 0);
    do_ret();
    chk("rst_then_unf", int'(o_underflow), 1);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 59) == 0, $urandom_range(0, 99) < 85,
          $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 50,
          $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 25,
          $urandom_range(0, 99) < 25, int'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/program_counter_stack.md
PROGRAM_COUNTER_STACK -- requirements
Module: program_counter_stack

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter and address width in bits, minimum 2.
REQ-002 SHALL have parameter DEPTH, default 4: return-stack entries, minimum 1.
REQ-003 SHALL have parameter RESET_VECTOR, default 0: counter value loaded by reset, WIDTH bits.
REQ-004 SHALL have port mclk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port mclk_en  input  1  clock enable; no state changes except reset when low.
REQ-007 SHALL have port i_counter_enable  input  1  request increment.
REQ-008 SHALL have port i_halt  input  1  freeze counter and stack.
REQ-009 SHALL have port i_load_enable  input  1  absolute jump to i_load_data.
REQ-010 SHALL have port i_call  input  1  push return address, jump to i_load_data.
REQ-011 SHALL have port i_return  input  1  pop stack top into counter.
REQ-012 SHALL have port i_load_data  input  WIDTH  jump/call target.
REQ-013 SHALL have port o_data  output  WIDTH  current counter value.
REQ-014 SHALL have port o_stack_top  output  WIDTH  top entry; 0 when stack empty.
REQ-015 SHALL have port o_stack_depth  output  $clog2(DEPTH+1)  occupied entries.
REQ-016 SHALL have port o_overflow  output  1  sticky: call attempted while full.
REQ-017 SHALL have port o_underflow  output  1  sticky: return attempted while empty.

Function
REQ-018 SHALL act only on cycles with mclk_en=1 and i_halt=0; otherwise hold all state; flags unchanged.
REQ-019 SHALL apply one operation per active cycle, priority: i_return > i_call > i_load_enable > i_counter_enable; lower requests ignored that cycle.
REQ-020 Increment SHALL be counter+1 modulo 2^WIDTH (all-ones wraps to 0).
REQ-021 Load SHALL set counter to i_load_data next cycle; stack unchanged.
REQ-022 Call, stack not full: push counter+1 (mod 2^WIDTH), counter <= i_load_data, depth+1.
REQ-023 Call, stack full: counter <= i_load_data, no push, depth unchanged, o_overflow <= 1.
REQ-024 Return, stack not empty: counter <= top entry, pop, depth-1.
REQ-025 Return, stack empty: counter unchanged, o_underflow <= 1.
REQ-026 All outputs SHALL be registered-state only; o_data reflects an operation one cycle after the active edge (latency 1).
REQ-027 Stack SHALL be LIFO; entries below the top are never modified by push/pop of the top.
REQ-028 o_overflow/o_underflow SHALL clear only on reset.

Reset
REQ-029 i_reset=1 at a rising edge SHALL set counter=RESET_VECTOR, depth=0, o_stack_top=0, o_overflow=0, o_underflow=0, regardless of mclk_en, i_halt, or any request.
REQ-030 Reset mid-sequence (e.g., nested calls) SHALL discard all stack contents; a following return underflows.
REQ-031 Stack storage contents need not be cleared; only depth/pointer and outputs.

Structure
REQ-032 No shared package required; all sizing derived from parameters as localparams inside the module.
REQ-033 One sub-module, return_stack (parametrised WIDTH, DEPTH: push, pop, top, depth, full, empty), SHALL hold stack storage and pointer; control and priority stay in program_counter_stack.

Verification
REQ-034 Reset, then 17 cycles i_counter_enable=1 (WIDTH=4) -> o_data 0,1,...,15,0,1; no flags.
REQ-035 o_data=5, i_call with i_load_data=12 -> o_data=12, o_stack_top=6, depth=1; then i_return -> o_data=6, depth=0.
REQ-036 DEPTH=4: five calls targeting 1,2,3,4,8 from o_data=0 -> depth=4, o_overflow=1, o_data=8, top=4; four returns -> o_data 4,3,2,1.
REQ-037 Empty stack, o_data=3, i_return -> o_data=3, o_underflow=1; o_underflow stays 1 until i_reset.
REQ-038 Simultaneous i_return+i_call+i_load_enable with top=9 -> o_data=9, no push; same with i_halt=1 or mclk_en=0 -> no change.
REQ-039 Call to 15 from o_data=15 (WIDTH=4) -> pushed 0; i_reset asserted with i_halt=1 -> o_data=RESET_VECTOR, depth=0.
